// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the rv32_pipe_core five-stage pipeline:
// opcode/funct constants, ALU and forwarding-select enums, and the
// contents of the four inter-stage pipeline registers.
package rv32_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        use_imm;
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] load_data;
  } mem_wb_t;

  // EX/MEM wins over MEM/WB because it holds the younger producer.
  function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                          input logic       exm_we,
                                          input logic [4:0] exm_rd,
                                          input logic       wb_we,
                                          input logic [4:0] wb_rd);
    if (exm_we && exm_rd != 5'd0 && exm_rd == rs) return FWD_MEM;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs)    return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/rv32_pipe_alu.sv
// Combinational ALU for rv32_pipe_core.
// Ports: op - operation select; a, b - operands; y - result
// (mul returns the low 32 bits of the product; shifts use b[4:0]).
module rv32_pipe_alu
  import rv32_pipe_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0] prod_lo;
  assign prod_lo = a * b;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRA: y = $signed(a) >>> b[4:0];
      ALU_MUL: y = prod_lo;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/rv32_pipe_core.sv
// Five-stage in-order RV32I-subset pipeline (IF, ID, EX, MEM, WB) with
// on-chip imem/dmem and register file, loaded by backdoor.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-low reset (clears PC and pipeline registers)
//   start_i - run enable; low holds the PC and feeds bubbles into IF/ID
// Optional: define PERF_CNT_EN to add stall_cnt_o / flush_cnt_o counters.
module rv32_pipe_core
  import rv32_pipe_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [31:0] rf   [0:31];

  logic [31:0] pc;
  if_id_t  if_id_q;
  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  // ---------------- WB ----------------
  logic [31:0] wb_data;
  logic        wb_we;
  assign wb_data = mem_wb_q.mem_to_reg ? mem_wb_q.load_data : mem_wb_q.alu_res;
  assign wb_we   = mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0);

  // ---------------- ID ----------------
  logic [31:0] id_instr, imm_i, imm_s, imm_b, rs1_val, rs2_val, branch_target;
  logic [6:0]  id_opcode, id_f7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_f3;
  logic        id_is_beq, stall, flush;

  assign id_instr  = if_id_q.instr;
  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_f3     = id_instr[14:12];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign id_f7     = id_instr[31:25];
  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                  id_instr[30:25], id_instr[11:8], 1'b0};

  // Write-through: a WB write to the register being read is seen this cycle.
  assign rs1_val = (id_rs1 == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_q.rd == id_rs1) ? wb_data : rf[id_rs1];
  assign rs2_val = (id_rs2 == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_q.rd == id_rs2) ? wb_data : rf[id_rs2];

  // Raw rs1/rs2 fields are compared regardless of instruction format.
  assign stall = id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                 ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));

  assign id_is_beq     = (id_opcode == OP_BRANCH) && (id_f3 == F3_BEQ);
  assign branch_target = if_id_q.pc + imm_b;
  // A stalled beq re-evaluates next cycle, so it may not flush now.
  assign flush = id_is_beq && (rs1_val == rs2_val) && !stall;

  always_comb begin
    id_ex_d         = '0;
    id_ex_d.rs1     = id_rs1;
    id_ex_d.rs2     = id_rs2;
    id_ex_d.rd      = id_rd;
    id_ex_d.rs1_val = rs1_val;
    id_ex_d.rs2_val = rs2_val;
    id_ex_d.imm     = imm_i;
    case (id_opcode)
      OP_R: begin
        if (id_f7 == F7_MUL && id_f3 == F3_ADD_SUB) begin
          id_ex_d.reg_write = 1'b1;
          id_ex_d.alu_op    = ALU_MUL;
        end else if (id_f7 == F7_ALT && id_f3 == F3_ADD_SUB) begin
          id_ex_d.reg_write = 1'b1;
          id_ex_d.alu_op    = ALU_SUB;
        end else if (id_f7 == F7_BASE) begin
          case (id_f3)
            F3_ADD_SUB: begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_ADD; end
            F3_AND:     begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_AND; end
            F3_XOR:     begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_XOR; end
            F3_SLL:     begin id_ex_d.reg_write = 1'b1; id_ex_d.alu_op = ALU_SLL; end
            default: ;
          endcase
        end
      end
      OP_IMM: begin
        if (id_f3 == F3_ADD_SUB) begin
          id_ex_d.reg_write = 1'b1;
          id_ex_d.use_imm   = 1'b1;
          id_ex_d.alu_op    = ALU_ADD;
        end else if (id_f3 == F3_SRA && id_f7 == F7_ALT) begin
          id_ex_d.reg_write = 1'b1;
          id_ex_d.use_imm   = 1'b1;
          id_ex_d.alu_op    = ALU_SRA;
        end
      end
      OP_LOAD: begin
        if (id_f3 == F3_WORD) begin
          id_ex_d.reg_write  = 1'b1;
          id_ex_d.mem_read   = 1'b1;
          id_ex_d.mem_to_reg = 1'b1;
          id_ex_d.use_imm    = 1'b1;
        end
      end
      OP_STORE: begin
        if (id_f3 == F3_WORD) begin
          id_ex_d.mem_write = 1'b1;
          id_ex_d.use_imm   = 1'b1;
          id_ex_d.imm       = imm_s;
        end
      end
      default: ;
    endcase
  end

  // ---------------- EX ----------------
  fwd_sel_e    fwd_a, fwd_b;
  logic [31:0] op_a, op_b_reg, alu_b, alu_y;

  assign fwd_a = fwd_select(id_ex_q.rs1, ex_mem_q.reg_write, ex_mem_q.rd,
                            mem_wb_q.reg_write, mem_wb_q.rd);
  assign fwd_b = fwd_select(id_ex_q.rs2, ex_mem_q.reg_write, ex_mem_q.rd,
                            mem_wb_q.reg_write, mem_wb_q.rd);

  assign op_a     = (fwd_a == FWD_MEM) ? ex_mem_q.alu_res :
                    (fwd_a == FWD_WB)  ? wb_data : id_ex_q.rs1_val;
  assign op_b_reg = (fwd_b == FWD_MEM) ? ex_mem_q.alu_res :
                    (fwd_b == FWD_WB)  ? wb_data : id_ex_q.rs2_val;
  assign alu_b    = id_ex_q.use_imm ? id_ex_q.imm : op_b_reg;

  rv32_pipe_alu u_alu (
    .op (id_ex_q.alu_op),
    .a  (op_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign ex_mem_d = '{reg_write:  id_ex_q.reg_write,
                      mem_write:  id_ex_q.mem_write,
                      mem_to_reg: id_ex_q.mem_to_reg,
                      rd:         id_ex_q.rd,
                      alu_res:    alu_y,
                      store_data: op_b_reg};

  // ---------------- MEM ----------------
  logic [31:0] load_data;
  assign load_data = dmem[ex_mem_q.alu_res[DA_W+1:2]];

  assign mem_wb_d = '{reg_write:  ex_mem_q.reg_write,
                      mem_to_reg: ex_mem_q.mem_to_reg,
                      rd:         ex_mem_q.rd,
                      alu_res:    ex_mem_q.alu_res,
                      load_data:  load_data};

  // ---------------- State ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc       <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      id_ex_q  <= stall ? id_ex_t'('0) : id_ex_d;
      if (stall) begin
        // PC and IF/ID hold for the single load-use stall cycle.
      end else if (flush) begin
        if_id_q <= '0;
        if (start_i) pc <= branch_target;
      end else if (start_i) begin
        pc      <= pc + 32'd4;
        if_id_q <= '{instr: imem[pc[IA_W+1:2]], pc: pc};
      end else begin
        if_id_q <= '0;
      end
    end
  end

  // NOTE: the storage arrays have no reset; they are loaded by backdoor and writes are only blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (rst_i && ex_mem_q.mem_write) dmem[ex_mem_q.alu_res[DA_W+1:2]] <= ex_mem_q.store_data;
    if (rst_i && wb_we) rf[mem_wb_q.rd] <= wb_data;
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && !id_is_beq) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush)               flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_pipe_core.sv
// Self-checking bench for rv32_pipe_core: small programs are loaded by
// backdoor, expected architectural state is queued, then compared after
// the program drains.
module tb_rv32_pipe_core;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  rv32_pipe_core dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  typedef enum {K_RF, K_DM, K_PC, K_STALL, K_FLUSH} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int n_cmp = 0;
  int n_err = 0;
  int stall_seen = 0, flush_seen = 0;
  int stall_base = 0, flush_base = 0;

  // Hazard-event monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (dut.stall) stall_seen++;
      if (dut.flush) flush_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // ---- instruction encoders ----
  function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, int rd, int rs1, int rs2);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] srai(int rd, int rs1, int sh);
    return {7'b0100000, sh[4:0], rs1[4:0], 3'b101, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq(int rs1, int rs2, int off);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  // ---- scoreboard ----
  task automatic expect_v(input string tag, input kind_e k, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RF:    act = dut.rf[e.idx];
        K_DM:    act = dut.dmem[e.idx];
        K_PC:    act = dut.pc;
        K_STALL: act = 32'(stall_seen - stall_base);
        default: act = 32'(flush_seen - flush_base);
      endcase
      check(e.tag, act, e.val);
    end
  endtask

  // Hold reset across one edge, then clear storage and load prog while the
  // pipe is all bubbles. Returns at a negedge with reset still asserted.
  task automatic enter_reset(input logic s);
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = s;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    for (int i = 0; i < 32; i++) begin
      dut.dmem[i] = 32'd0;
      dut.rf[i]   = 32'd0;
    end
  endtask

  task automatic release_reset();
    rst_i      = 1'b1;
    stall_base = stall_seen;
    flush_base = flush_seen;
  endtask

  task automatic run_and_drain(input int cycles);
    repeat (cycles) @(negedge clk_i);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset then NOPs ----
    prog.delete();
    enter_reset(1'b1);
    dut.rf[1]   = 32'hdeadbeef;
    dut.dmem[0] = 32'hcafef00d;
    release_reset();
    expect_v("pc_reset", K_PC, 0, 32'd0);
    drain();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      expect_v($sformatf("pc_nop%0d", k), K_PC, 0, 32'(4 * k));
      drain();
    end
    expect_v("nop_rf1", K_RF, 1, 32'hdeadbeef);
    expect_v("nop_dm0", K_DM, 0, 32'hcafef00d);
    run_and_drain(10);

    // ---- forwarding (incl. EX/MEM priority over MEM/WB) ----
    prog.delete();
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 1, 3));
    prog.push_back(rtype(7'b0, 3'b000, 3, 1, 2));
    prog.push_back(addi(21, 0, 1));
    prog.push_back(addi(21, 0, 2));
    prog.push_back(rtype(7'b0, 3'b000, 22, 21, 21));
    enter_reset(1'b1);
    release_reset();
    expect_v("fwd_x1", K_RF, 1, 32'd5);
    expect_v("fwd_x2", K_RF, 2, 32'd8);
    expect_v("fwd_x3", K_RF, 3, 32'd13);
    expect_v("fwd_prio_x22", K_RF, 22, 32'd4);
    expect_v("fwd_stalls", K_STALL, 0, 32'd0);
    run_and_drain(20);

    // ---- load-use ----
    prog.delete();
    prog.push_back(lw(4, 0, 0));
    prog.push_back(rtype(7'b0, 3'b000, 5, 4, 4));
    enter_reset(1'b1);
    dut.dmem[0] = 32'd5;
    release_reset();
    expect_v("lu_x4", K_RF, 4, 32'd5);
    expect_v("lu_x5", K_RF, 5, 32'd10);
    expect_v("lu_stalls", K_STALL, 0, 32'd1);
    run_and_drain(20);

    // ---- store / srai / mul ----
    prog.delete();
    prog.push_back(addi(6, 0, -3));
    prog.push_back(srai(7, 6, 1));
    prog.push_back(rtype(7'b0000001, 3'b000, 8, 6, 6));
    prog.push_back(sw(8, 0, 4));
    enter_reset(1'b1);
    release_reset();
    expect_v("mix_x6", K_RF, 6, 32'hfffffffd);
    expect_v("mix_x7", K_RF, 7, 32'hfffffffe);
    expect_v("mix_x8", K_RF, 8, 32'd9);
    expect_v("mix_dm1", K_DM, 1, 32'd9);
    run_and_drain(20);

    // ---- remaining ALU ops and unsupported encodings ----
    prog.delete();
    prog.push_back(addi(10, 0, 12));
    prog.push_back(addi(11, 0, 10));
    prog.push_back(rtype(7'b0, 3'b111, 12, 10, 11));
    prog.push_back(rtype(7'b0, 3'b100, 13, 10, 11));
    prog.push_back(rtype(7'b0, 3'b001, 14, 11, 10));
    prog.push_back(rtype(7'b0100000, 3'b000, 15, 11, 10));
    prog.push_back(rtype(7'b0000010, 3'b000, 16, 10, 11));
    prog.push_back(rtype(7'b0, 3'b010, 17, 10, 11));
    enter_reset(1'b1);
    dut.rf[16] = 32'h55;
    dut.rf[17] = 32'h66;
    release_reset();
    expect_v("alu_and", K_RF, 12, 32'd8);
    expect_v("alu_xor", K_RF, 13, 32'd6);
    expect_v("alu_sll", K_RF, 14, 32'h0000a000);
    expect_v("alu_sub", K_RF, 15, 32'hfffffffe);
    expect_v("bad_f7_nop", K_RF, 16, 32'h55);
    expect_v("bad_f3_nop", K_RF, 17, 32'h66);
    run_and_drain(20);

    // ---- branch taken ----
    prog.delete();
    prog.push_back(addi(1, 0, 1));
    prog.push_back(32'd0);
    prog.push_back(32'd0);
    prog.push_back(32'd0);
    prog.push_back(beq(1, 1, 8));
    prog.push_back(addi(9, 0, 7));
    prog.push_back(addi(20, 0, 3));
    enter_reset(1'b1);
    release_reset();
    expect_v("br_t_x9", K_RF, 9, 32'd0);
    expect_v("br_t_x20", K_RF, 20, 32'd3);
    expect_v("br_t_flush", K_FLUSH, 0, 32'd1);
    run_and_drain(20);
`ifdef PERF_CNT_EN
    check("perf_flush", flush_cnt_o, 32'd1);
    check("perf_stall", stall_cnt_o, 32'd0);
`endif

    // ---- branch not taken ----
    prog[4] = beq(1, 0, 8);
    enter_reset(1'b1);
    release_reset();
    expect_v("br_n_x9", K_RF, 9, 32'd7);
    expect_v("br_n_x20", K_RF, 20, 32'd3);
    expect_v("br_n_flush", K_FLUSH, 0, 32'd0);
    run_and_drain(20);

    // ---- start gating ----
    prog.delete();
    prog.push_back(addi(10, 10, 1));
    enter_reset(1'b0);
    release_reset();
    expect_v("start_pc0", K_PC, 0, 32'd0);
    drain();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      expect_v($sformatf("start_hold%0d", k), K_PC, 0, 32'd0);
      drain();
    end
    start_i = 1'b1;
    @(negedge clk_i);
    expect_v("start_pc4", K_PC, 0, 32'd4);
    drain();
    @(negedge clk_i);
    expect_v("start_pc8", K_PC, 0, 32'd8);
    drain();
    expect_v("start_x10_once", K_RF, 10, 32'd1);
    run_and_drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
